// File: rtl/pll_rst_pkg.sv
// ============================================================================
// Module : pll_rst_pkg
// Brief  : Shared state encoding and default constants for the PLL reset sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pll_rst_pkg;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_LOCK_QUAL_CYCLES = 1024;
  localparam int DEF_RELEASE_CYCLES   = 16;
  localparam int DEF_LOSS_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_QUAL = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync_bit.sv
// ============================================================================
// Module : rst_sync_bit
// Brief  : STAGES-deep async-clear single-bit synchronizer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rst_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_reset_ctrl.sv
// ============================================================================
// Module : pll_lock_reset_ctrl
// Brief  : Qualifies PLL lock / init-done / external reset and sequences the
//          fabric reset release; keeps a saturating lock-loss count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_lock_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int LOCK_QUAL_CYCLES = DEF_LOCK_QUAL_CYCLES,
  parameter int RELEASE_CYCLES   = DEF_RELEASE_CYCLES,
  parameter int LOSS_CNT_W       = DEF_LOSS_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  PLL_LOCK,
  input  logic                  INIT_DONE,
  input  logic                  EXT_RST_N,
  output logic                  FABRIC_RESET_N,
  output logic                  LOCK_STABLE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [1:0]            SEQ_STATE
);

  localparam int CNT_W = $clog2(max_int(LOCK_QUAL_CYCLES, RELEASE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RELEASE_CYCLES - 1);

  logic lock_s;
  logic init_s;
  logic ext_s;
  logic go_s;

  seq_state_t             state;
  seq_state_t             next_state;
  logic [CNT_W-1:0]       qual_cnt;
  logic [CNT_W-1:0]       qual_cnt_next;
  logic                   release_next;
  logic                   loss_inc;
  logic [LOSS_CNT_W-1:0]  loss_cnt;

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (INIT_DONE),
    .q     (init_s)
  );

  rst_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (EXT_RST_N),
    .q     (ext_s)
  );

  assign go_s = lock_s & init_s & ext_s;

  // Outputs are registered from next_state so they switch on the same edge as the state.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state          <= ST_WAIT;
      qual_cnt       <= '0;
      FABRIC_RESET_N <= 1'b0;
      LOCK_STABLE    <= 1'b0;
      loss_cnt       <= '0;
    end else begin
      state          <= next_state;
      qual_cnt       <= qual_cnt_next;
      FABRIC_RESET_N <= release_next;
      LOCK_STABLE    <= release_next;
      if (loss_inc) begin
        loss_cnt <= loss_cnt + 1'b1;
      end
    end
  end

  // Any go_s drop during qualification returns to WAIT with no partial credit.
  always_comb begin
    next_state    = state;
    qual_cnt_next = '0;
    unique case (state)
      ST_WAIT: begin
        if (go_s) next_state = ST_QUAL;
      end
      ST_QUAL: begin
        if (!go_s)                  next_state = ST_WAIT;
        else if (qual_cnt == QUAL_LAST) next_state = ST_HOLD;
        else                        qual_cnt_next = qual_cnt + 1'b1;
      end
      ST_HOLD: begin
        if (!go_s)                  next_state = ST_WAIT;
        else if (qual_cnt == HOLD_LAST) next_state = ST_RUN;
        else                        qual_cnt_next = qual_cnt + 1'b1;
      end
      ST_RUN: begin
        if (!go_s) next_state = ST_WAIT;
      end
      default: begin
        next_state = ST_WAIT;
      end
    endcase
  end

  always_comb begin
    release_next = (next_state == ST_RUN);
    loss_inc     = (state == ST_RUN) && !lock_s && (loss_cnt != '1);
  end

  assign LOCK_LOSS_CNT = loss_cnt;
  assign SEQ_STATE     = state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_ctrl.sv
// ============================================================================
// Module : tb_pll_lock_reset_ctrl
// Brief  : Directed scoreboard bench for the PLL lock reset sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_reset_ctrl;

  localparam int SYNC     = 2;
  localparam int QUAL     = 8;
  localparam int REL      = 4;
  localparam int LAT      = SYNC + 1 + QUAL + REL;
  localparam int REASSERT = SYNC + 1;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       PLL_LOCK;
  logic       INIT_DONE;
  logic       EXT_RST_N;
  logic       frn, stable;
  logic [7:0] loss_cnt;
  logic [1:0] seq_state;
  logic       frn_s, stable_s;
  logic [1:0] loss_cnt_s;
  logic [1:0] seq_state_s;

  typedef struct {
    string      tag;
    logic       frn;
    logic       stable;
    logic [1:0] st;
    logic [7:0] cnt;
    logic [1:0] cnt_sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   losses = 0;

  always #5 CLK = ~CLK;

  pll_lock_reset_ctrl #(
    .SYNC_STAGES(SYNC), .LOCK_QUAL_CYCLES(QUAL), .RELEASE_CYCLES(REL), .LOSS_CNT_W(8)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .EXT_RST_N(EXT_RST_N), .FABRIC_RESET_N(frn), .LOCK_STABLE(stable),
    .LOCK_LOSS_CNT(loss_cnt), .SEQ_STATE(seq_state)
  );

  pll_lock_reset_ctrl #(
    .SYNC_STAGES(SYNC), .LOCK_QUAL_CYCLES(QUAL), .RELEASE_CYCLES(REL), .LOSS_CNT_W(2)
  ) dut_sat (
    .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .EXT_RST_N(EXT_RST_N), .FABRIC_RESET_N(frn_s), .LOCK_STABLE(stable_s),
    .LOCK_LOSS_CNT(loss_cnt_s), .SEQ_STATE(seq_state_s)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic e_frn, input logic e_stable, input logic [1:0] e_st);
    exp_t e;
    e.tag     = tag;
    e.frn     = e_frn;
    e.stable  = e_stable;
    e.st      = e_st;
    e.cnt     = (losses > 255) ? 8'd255 : 8'(losses);
    e.cnt_sat = (losses > 3) ? 2'd3 : 2'(losses);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "fabric_reset_n", {7'd0, frn},        {7'd0, e.frn});
      cmp(e.tag, "lock_stable",    {7'd0, stable},     {7'd0, e.stable});
      cmp(e.tag, "seq_state",      {6'd0, seq_state},  {6'd0, e.st});
      cmp(e.tag, "lock_loss_cnt",  loss_cnt,           e.cnt);
      cmp(e.tag, "sat_loss_cnt",   {6'd0, loss_cnt_s}, {6'd0, e.cnt_sat});
      cmp(e.tag, "sat_fabric_rst", {7'd0, frn_s},      {7'd0, e.frn});
    end
  endtask

  task automatic expect_at(input int n, input string tag, input logic e_frn, input logic e_stable, input logic [1:0] e_st);
    push(tag, e_frn, e_stable, e_st);
    tick(n);
    pop_check();
  endtask

  // Entered just after an edge with the design in RUN; that edge is edge 0.
  task automatic drop_and_recover(input string tag, input logic drop_lock, input logic drop_ext, input int low_cycles);
    if (drop_lock) PLL_LOCK = 1'b0;
    if (drop_ext)  EXT_RST_N = 1'b0;
    expect_at(REASSERT - 1, {tag, "_still_run"}, 1'b1, 1'b1, 2'd3);
    if (drop_lock) losses++;
    expect_at(1, {tag, "_asserted"}, 1'b0, 1'b0, 2'd0);
    tick(low_cycles - REASSERT);
    PLL_LOCK  = 1'b1;
    EXT_RST_N = 1'b1;
    expect_at(LAT - 1, {tag, "_pre_release"}, 1'b0, 1'b0, 2'd2);
    expect_at(1, {tag, "_release"}, 1'b1, 1'b1, 2'd3);
  endtask

  // Async reset applied between edges; observed before the next edge.
  task automatic pulse_reset_low();
    #2;
    RESETN = 1'b0;
    losses = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESETN    = 1'b0;
    PLL_LOCK  = 1'b0;
    INIT_DONE = 1'b0;
    EXT_RST_N = 1'b0;
    expect_at(3, "reset", 1'b0, 1'b0, 2'd0);

    PLL_LOCK  = 1'b1;
    INIT_DONE = 1'b1;
    EXT_RST_N = 1'b1;
    expect_at(3, "reset_inputs_high", 1'b0, 1'b0, 2'd0);

    PLL_LOCK = 1'b0;
    tick(1);
    RESETN = 1'b1;
    expect_at(5, "wait_no_lock", 1'b0, 1'b0, 2'd0);

    // Clean power-up: lock rises after edge 0.
    PLL_LOCK = 1'b1;
    expect_at(REASSERT, "pwrup_qual", 1'b0, 1'b0, 2'd1);
    expect_at(LAT - 1 - REASSERT, "pwrup_pre", 1'b0, 1'b0, 2'd2);
    expect_at(1, "pwrup_release", 1'b1, 1'b1, 2'd3);

    drop_and_recover("lock_loss", 1'b1, 1'b0, 3);
    drop_and_recover("simul_drop", 1'b1, 1'b1, 3);
    drop_and_recover("ext_only", 1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      drop_and_recover("sat_loss", 1'b1, 1'b0, 4);
    end

    // Async reset from RUN with a non-zero loss count.
    pulse_reset_low();
    expect_at(0, "async_rst_run", 1'b0, 1'b0, 2'd0);
    expect_at(2, "async_rst_held", 1'b0, 1'b0, 2'd0);
    RESETN = 1'b1;
    expect_at(LAT - 1, "rst_run_pre", 1'b0, 1'b0, 2'd2);
    expect_at(1, "rst_run_release", 1'b1, 1'b1, 2'd3);

    // Lock glitch during QUAL.
    pulse_reset_low();
    tick(1);
    RESETN = 1'b1;
    expect_at(6, "glitch_in_qual", 1'b0, 1'b0, 2'd1);
    PLL_LOCK = 1'b0;
    expect_at(2, "glitch_still_qual", 1'b0, 1'b0, 2'd1);
    PLL_LOCK = 1'b1;
    expect_at(1, "glitch_to_wait", 1'b0, 1'b0, 2'd0);
    expect_at(LAT - 2, "glitch_pre", 1'b0, 1'b0, 2'd2);
    expect_at(1, "glitch_release", 1'b1, 1'b1, 2'd3);

    // Async reset mid-HOLD.
    pulse_reset_low();
    tick(1);
    RESETN = 1'b1;
    expect_at(LAT - 2, "in_hold", 1'b0, 1'b0, 2'd2);
    pulse_reset_low();
    expect_at(0, "async_rst_hold", 1'b0, 1'b0, 2'd0);
    RESETN = 1'b1;
    expect_at(LAT - 1, "hold_rst_pre", 1'b0, 1'b0, 2'd2);
    expect_at(1, "hold_rst_release", 1'b1, 1'b1, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
